// File: rtl/cipher_pkg.sv
// Shared definitions for the PL cipher core and the logic that arbitrates access to it.
package cipher_pkg;

    localparam int CIPHER_DATA_W = 4;
    localparam int LAT_CNT_W     = 4;

    localparam logic MODE_ENCRYPT = 1'b1;
    localparam logic MODE_DECRYPT = 1'b0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE_WAIT = 2'd1,
        RESP       = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The pointer names the favoured requester; it moves to
// the non-served requester whenever i_update is pulsed.
module rr_arbiter2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_update,
    input  logic i_served_b,
    output logic o_grant_a,
    output logic o_grant_b
);

    logic ptr_b;

    // Favoured requester wins if it is asking; otherwise the other one may take it.
    assign o_grant_a = i_req_a & (~ptr_b | ~i_req_b);
    assign o_grant_b = i_req_b & ( ptr_b | ~i_req_a);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_b <= 1'b0;
        end else if (i_update) begin
            ptr_b <= ~i_served_b;
        end
    end

endmodule

// File: rtl/cipher_core_arbiter.sv
// Shares the single PL encrypt/decrypt core between the PS GPIO channel (A) and PL
// stream logic (B); one transaction in flight, result routed back to its issuer only.
module cipher_core_arbiter
    import cipher_pkg::*;
#(
    parameter int DATA_W       = CIPHER_DATA_W,
    parameter int CORE_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_a_req_valid,
    output logic              o_a_req_ready,
    input  logic              i_a_req_mode,
    input  logic [DATA_W-1:0] i_a_req_data,
    output logic              o_a_rsp_valid,
    input  logic              i_a_rsp_ready,
    output logic [DATA_W-1:0] o_a_rsp_data,

    input  logic              i_b_req_valid,
    output logic              o_b_req_ready,
    input  logic              i_b_req_mode,
    input  logic [DATA_W-1:0] i_b_req_data,
    output logic              o_b_rsp_valid,
    input  logic              i_b_rsp_ready,
    output logic [DATA_W-1:0] o_b_rsp_data,

    output logic              o_core_mode,
    output logic [DATA_W-1:0] o_core_message,
    input  logic [DATA_W-1:0] i_core_result,

    output logic              o_busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(CORE_LATENCY);

    arb_state_t           state;
    logic                 owner_b;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 grant_a;
    logic                 grant_b;
    logic                 idle;
    logic                 accept_a;
    logic                 accept_b;
    logic                 rsp_done;

    rr_arbiter2 u_rr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_a    (i_a_req_valid),
        .i_req_b    (i_b_req_valid),
        .i_update   (rsp_done),
        .i_served_b (owner_b),
        .o_grant_a  (grant_a),
        .o_grant_b  (grant_b)
    );

    assign idle     = (state == IDLE);
    // Ready is masked while reset is held so nothing appears accepted during reset.
    assign accept_a = i_rst_n & idle & grant_a;
    assign accept_b = i_rst_n & idle & grant_b;
    assign rsp_done = (state == RESP) & (owner_b ? i_b_rsp_ready : i_a_rsp_ready);

    assign o_a_req_ready = accept_a;
    assign o_b_req_ready = accept_b;
    assign o_busy        = ~idle;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            owner_b        <= 1'b0;
            lat_cnt        <= '0;
            o_core_mode    <= 1'b0;
            o_core_message <= '0;
            o_a_rsp_valid  <= 1'b0;
            o_b_rsp_valid  <= 1'b0;
            o_a_rsp_data   <= '0;
            o_b_rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_a || accept_b) begin
                        o_core_mode    <= accept_b ? i_b_req_mode : i_a_req_mode;
                        o_core_message <= accept_b ? i_b_req_data : i_a_req_data;
                        owner_b        <= accept_b;
                        lat_cnt        <= LAT_LOAD;
                        state          <= ISSUE_WAIT;
                    end
                end
                ISSUE_WAIT: begin
                    // Core inputs stay put while the counter walks the core latency down.
                    if (lat_cnt == '0) begin
                        if (owner_b) begin
                            o_b_rsp_data  <= i_core_result;
                            o_b_rsp_valid <= 1'b1;
                        end else begin
                            o_a_rsp_data  <= i_core_result;
                            o_a_rsp_valid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        o_a_rsp_valid <= 1'b0;
                        o_b_rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
